// File: rtl/dmem_arbiter.sv
// rtl/dmem_arbiter.sv - single-port data-memory arbiter between the CPU MEM stage and a debug/loader port
// Optional feature: DMEM_ARB_FAIRNESS_EN adds a starvation counter that forces a debug grant.
module dmem_arbiter #(
    parameter int STARVE_LIMIT = 4,
    parameter int ADDR_W       = 8
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              cpu_req,
    input  logic              cpu_rw,
    input  logic              cpu_size,
    input  logic [ADDR_W-1:0] cpu_addr,
    input  logic [31:0]       cpu_wdata,
    output logic [31:0]       cpu_rdata,
    output logic              cpu_stall,
    input  logic              dbg_req,
    input  logic              dbg_rw,
    input  logic              dbg_size,
    input  logic [ADDR_W-1:0] dbg_addr,
    input  logic [31:0]       dbg_wdata,
    output logic              dbg_gnt,
    output logic [31:0]       dbg_rdata,
    output logic              dbg_valid,
    output logic              mem_enable,
    output logic              mem_rw,
    output logic              mem_size,
    output logic [ADDR_W-1:0] mem_addr,
    output logic [31:0]       mem_wdata,
    input  logic [31:0]       mem_rdata
);

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_CPU  = 2'd1,
        ST_DBG  = 2'd2
    } owner_t;

    owner_t state, next_state;
    logic   gnt_dbg;
    logic   gnt_cpu;
    logic   dbg_rd_q;

    if (STARVE_LIMIT < 1 || STARVE_LIMIT > 15) begin : g_bad_limit
        $error("dmem_arbiter: STARVE_LIMIT must be in 1..15");
    end

`ifdef DMEM_ARB_FAIRNESS_EN
    localparam logic [3:0] LIMIT = 4'(STARVE_LIMIT);
    logic [3:0] starve_cnt;

    assign gnt_dbg = dbg_req & (~cpu_req | (starve_cnt == LIMIT));

    // Cleared on every debug grant, so a held cpu_req never sees two stalls in a row.
    always_ff @(posedge clk) begin
        if (reset) begin
            starve_cnt <= 4'd0;
        end else if (gnt_dbg || !dbg_req) begin
            starve_cnt <= 4'd0;
        end else if (starve_cnt != LIMIT) begin
            starve_cnt <= starve_cnt + 4'd1;
        end
    end
`else
    assign gnt_dbg = dbg_req & ~cpu_req;
`endif

    assign gnt_cpu   = cpu_req & ~gnt_dbg;
    assign cpu_stall = cpu_req & gnt_dbg;
    assign dbg_gnt   = gnt_dbg;
    assign cpu_rdata = mem_rdata;

    always_ff @(posedge clk) begin
        if (reset) begin
            state <= ST_IDLE;
        end else begin
            state <= next_state;
        end
    end

    always_comb begin
        next_state = ST_IDLE;
        if (gnt_dbg) begin
            next_state = ST_DBG;
        end else if (gnt_cpu) begin
            next_state = ST_CPU;
        end
    end

    always_comb begin
        mem_enable = 1'b0;
        mem_rw     = 1'b0;
        mem_size   = 1'b0;
        mem_addr   = '0;
        mem_wdata  = 32'd0;
        case (next_state)
            ST_DBG: begin
                mem_enable = 1'b1;
                mem_rw     = dbg_rw;
                mem_size   = dbg_size;
                mem_addr   = dbg_addr;
                mem_wdata  = dbg_wdata;
            end
            ST_CPU: begin
                mem_enable = 1'b1;
                mem_rw     = cpu_rw;
                mem_size   = cpu_size;
                mem_addr   = cpu_addr;
                mem_wdata  = cpu_wdata;
            end
            default: ;
        endcase
    end

    // Read data is captured at the grant edge; the strobe is the previous owner being a debug read.
    always_ff @(posedge clk) begin
        if (reset) begin
            dbg_rd_q  <= 1'b0;
            dbg_rdata <= 32'd0;
        end else begin
            dbg_rd_q <= gnt_dbg & ~dbg_rw;
            if (gnt_dbg && !dbg_rw) begin
                dbg_rdata <= mem_rdata;
            end
        end
    end

    assign dbg_valid = (state == ST_DBG) & dbg_rd_q;

endmodule

// File: tb/tb_dmem_arbiter.sv
// tb/tb_dmem_arbiter.sv - scoreboard testbench for dmem_arbiter
module tb_dmem_arbiter;

`ifdef DMEM_ARB_FAIRNESS_EN
    localparam bit FAIR = 1'b1;
`else
    localparam bit FAIR = 1'b0;
`endif

    logic        clk = 1'b0;
    logic        reset;
    logic        cpu_req, cpu_rw, cpu_size;
    logic [7:0]  cpu_addr;
    logic [31:0] cpu_wdata, cpu_rdata;
    logic        cpu_stall;
    logic        dbg_req, dbg_rw, dbg_size;
    logic [7:0]  dbg_addr;
    logic [31:0] dbg_wdata;
    logic        dbg_gnt;
    logic [31:0] dbg_rdata;
    logic        dbg_valid;
    logic        mem_enable, mem_rw, mem_size;
    logic [7:0]  mem_addr;
    logic [31:0] mem_wdata, mem_rdata;

    always #5 clk = ~clk;

    dmem_arbiter #(.STARVE_LIMIT(4), .ADDR_W(8)) dut (
        .clk(clk), .reset(reset),
        .cpu_req(cpu_req), .cpu_rw(cpu_rw), .cpu_size(cpu_size),
        .cpu_addr(cpu_addr), .cpu_wdata(cpu_wdata), .cpu_rdata(cpu_rdata),
        .cpu_stall(cpu_stall),
        .dbg_req(dbg_req), .dbg_rw(dbg_rw), .dbg_size(dbg_size),
        .dbg_addr(dbg_addr), .dbg_wdata(dbg_wdata), .dbg_gnt(dbg_gnt),
        .dbg_rdata(dbg_rdata), .dbg_valid(dbg_valid),
        .mem_enable(mem_enable), .mem_rw(mem_rw), .mem_size(mem_size),
        .mem_addr(mem_addr), .mem_wdata(mem_wdata), .mem_rdata(mem_rdata)
    );

    typedef struct {
        int          idx;
        logic        en, rw, sz;
        logic [7:0]  addr;
        logic [31:0] wd;
        logic        stall, gnt, valid;
        logic [31:0] rdata, crd;
    } exp_t;

    exp_t sb[$];
    int   errors = 0;
    int   checks = 0;
    int   step_no = 0;

    task automatic chk(input string name, input int idx, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s step %0d: got %h expected %h", name, idx, act, exp);
        end
    endtask

    // owner: 0 = none, 1 = cpu, 2 = debug (hand-chosen per vector)
    task automatic step(input logic rst,
                        input logic cr, input logic crw, input logic csz, input logic [7:0] ca, input logic [31:0] cwd,
                        input logic dr, input logic drw, input logic dsz, input logic [7:0] da, input logic [31:0] dwd,
                        input logic [31:0] mrd, input int owner, input logic e_valid, input logic [31:0] e_rdata);
        exp_t e;
        @(posedge clk);
        #1;
        reset = rst;
        cpu_req = cr;  cpu_rw = crw;  cpu_size = csz;  cpu_addr = ca;  cpu_wdata = cwd;
        dbg_req = dr;  dbg_rw = drw;  dbg_size = dsz;  dbg_addr = da;  dbg_wdata = dwd;
        mem_rdata = mrd;
        e.idx   = step_no;
        e.en    = (owner != 0);
        e.rw    = (owner == 1) ? crw : (owner == 2) ? drw : 1'b0;
        e.sz    = (owner == 1) ? csz : (owner == 2) ? dsz : 1'b0;
        e.addr  = (owner == 1) ? ca  : (owner == 2) ? da  : 8'h00;
        e.wd    = (owner == 1) ? cwd : (owner == 2) ? dwd : 32'h0;
        e.gnt   = (owner == 2);
        e.stall = cr && (owner == 2);
        e.valid = e_valid;
        e.rdata = e_rdata;
        e.crd   = mrd;
        sb.push_back(e);
        step_no++;
    endtask

    task automatic idle(input logic rst, input logic e_valid, input logic [31:0] e_rdata);
        step(rst, 0, 0, 0, 8'h00, 32'h0, 0, 0, 0, 8'h00, 32'h0, 32'h0, 0, e_valid, e_rdata);
    endtask

    initial begin : monitor
        exp_t e;
        forever begin
            @(negedge clk);
            if (sb.size() > 0) begin
                e = sb.pop_front();
                chk("mem_enable", e.idx, {31'd0, mem_enable}, {31'd0, e.en});
                chk("mem_rw",     e.idx, {31'd0, mem_rw},     {31'd0, e.rw});
                chk("mem_size",   e.idx, {31'd0, mem_size},   {31'd0, e.sz});
                chk("mem_addr",   e.idx, {24'd0, mem_addr},   {24'd0, e.addr});
                chk("mem_wdata",  e.idx, mem_wdata,           e.wd);
                chk("cpu_stall",  e.idx, {31'd0, cpu_stall},  {31'd0, e.stall});
                chk("dbg_gnt",    e.idx, {31'd0, dbg_gnt},    {31'd0, e.gnt});
                chk("dbg_valid",  e.idx, {31'd0, dbg_valid},  {31'd0, e.valid});
                chk("dbg_rdata",  e.idx, dbg_rdata,           e.rdata);
                chk("cpu_rdata",  e.idx, cpu_rdata,           e.crd);
            end
        end
    end

    initial begin : stimulus
        logic [31:0] r_loop;
        int          t;
        reset = 1'b1;
        cpu_req = 0; cpu_rw = 0; cpu_size = 0; cpu_addr = 8'h00; cpu_wdata = 32'h0;
        dbg_req = 0; dbg_rw = 0; dbg_size = 0; dbg_addr = 8'h00; dbg_wdata = 32'h0;
        mem_rdata = 32'h0;
        repeat (2) @(posedge clk);

        idle(0, 0, 32'h0);
        step(0, 0, 0, 0, 8'h00, 32'h0, 1, 0, 1, 8'h10, 32'h0, 32'hE3A01005, 2, 0, 32'h0);
        idle(0, 1, 32'hE3A01005);
        idle(0, 0, 32'hE3A01005);
        step(0, 1, 1, 1, 8'h20, 32'h0000002A, 0, 0, 0, 8'h00, 32'h0, 32'h0, 1, 0, 32'hE3A01005);
        step(0, 1, 0, 0, 8'h21, 32'h0, 0, 0, 0, 8'h00, 32'h0, 32'h00000055, 1, 0, 32'hE3A01005);
        step(0, 0, 0, 0, 8'h00, 32'h0, 1, 1, 1, 8'h30, 32'hDEADBEEF, 32'h0, 2, 0, 32'hE3A01005);
        idle(0, 0, 32'hE3A01005);
        step(0, 0, 0, 0, 8'h00, 32'h0, 1, 0, 1, 8'h11, 32'h0, 32'h12345678, 2, 0, 32'hE3A01005);
        step(0, 0, 0, 0, 8'h00, 32'h0, 1, 0, 1, 8'h11, 32'h0, 32'hCAFEF00D, 2, 1, 32'h12345678);
        idle(0, 1, 32'hCAFEF00D);

        for (int i = 0; i < 20; i++) begin
            step(0, 1, 0, 1, 8'h60, 32'h0, 1, 0, 1, 8'h50, 32'h0, 32'h0BADCAFE,
                 (FAIR && (i % 5 == 4)) ? 2 : 1,
                 FAIR && (i % 5 == 0) && (i > 0),
                 (FAIR && i > 4) ? 32'h0BADCAFE : 32'hCAFEF00D);
        end
        r_loop = FAIR ? 32'h0BADCAFE : 32'hCAFEF00D;
        idle(0, FAIR, r_loop);
        idle(0, 0, r_loop);

        step(0, 0, 0, 0, 8'h00, 32'h0, 1, 0, 0, 8'h40, 32'h0, 32'h11112222, 2, 0, r_loop);
        idle(1, 1, 32'h11112222);
        idle(0, 0, 32'h0);
        step(1, 0, 0, 0, 8'h00, 32'h0, 1, 0, 1, 8'h44, 32'h0, 32'h33334444, 2, 0, 32'h0);
        idle(0, 0, 32'h0);
        idle(0, 0, 32'h0);

        t = 0;
        while (sb.size() != 0 && t < 20) begin
            @(posedge clk);
            t++;
        end
        if (sb.size() != 0) begin
            checks++;
            errors++;
            $display("FAIL drain: %0d entries left, expected 0", sb.size());
        end
        #1;
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/dmem_arbiter.md
DMEM_ARBITER -- requirements
Module: dmem_arbiter

Interface
REQ-001 Parameter STARVE_LIMIT, default 4: consecutive denied debug cycles before a forced debug grant (1..15).
REQ-002 Parameter ADDR_W, default 8: data-memory byte-address width.
REQ-003 clk  in  1  single clock; all state updates on rising edge.
REQ-004 reset  in  1  synchronous, active-high reset.
REQ-005 cpu_req  in  1  MEM-stage access request (MEM_enable_instr).
REQ-006 cpu_rw  in  1  1=write, 0=read.
REQ-007 cpu_size  in  1  0=byte, 1=word.
REQ-008 cpu_addr  in  ADDR_W  MEM-stage address.
REQ-009 cpu_wdata  in  32  store data.
REQ-010 cpu_rdata  out  32  load data, combinational from mem_rdata.
REQ-011 cpu_stall  out  1  pipeline hold: PC, IF/ID, ID/EX, EX/MEM, MEM/WB freeze.
REQ-012 dbg_req, dbg_rw, dbg_size  in  1 each  debug/loader port request and controls.
REQ-013 dbg_addr  in  ADDR_W; dbg_wdata  in  32  debug address and write data.
REQ-014 dbg_gnt  out  1  access performed this cycle.
REQ-015 dbg_rdata  out  32; dbg_valid  out  1  registered read data and its one-cycle strobe.
REQ-016 mem_enable, mem_rw, mem_size  out  1 each; mem_addr  out  ADDR_W; mem_wdata  out  32; mem_rdata  in  32  single-port data-memory interface.

Function
REQ-017 Per cycle exactly one owner SHALL be chosen combinationally: DBG, CPU or NONE.
REQ-018 gnt_dbg SHALL = dbg_req AND (NOT cpu_req OR starve_cnt == STARVE_LIMIT); gnt_cpu SHALL = cpu_req AND NOT gnt_dbg.
REQ-019 mem_* outputs SHALL mirror the owner's controls/address/data; owner NONE SHALL drive all mem_* outputs to 0.
REQ-020 cpu_stall SHALL = cpu_req AND gnt_dbg, combinational, same cycle.
REQ-021 dbg_gnt SHALL = gnt_dbg; debug side SHALL hold req/controls stable until dbg_gnt; a held dbg_req after dbg_gnt SHALL be a new access.
REQ-022 On a granted debug read, dbg_rdata SHALL capture mem_rdata at that edge and dbg_valid SHALL be 1 for exactly the next cycle; debug writes SHALL never raise dbg_valid; dbg_rdata SHALL hold its value otherwise.
REQ-023 starve_cnt (4 bits) SHALL increment when dbg_req AND NOT gnt_dbg, saturating at STARVE_LIMIT, and clear when gnt_dbg or NOT dbg_req.
REQ-024 Registered state SHALL be {IDLE, CPU, DBG} = previous-cycle owner; transitions follow REQ-017 each edge.
REQ-025 Since starve_cnt clears on debug grant, cpu_stall SHALL never be asserted in two consecutive cycles while cpu_req is held (fairness compiled in).
REQ-026 cpu_rdata SHALL equal mem_rdata regardless of owner; CPU SHALL ignore it while cpu_stall=1.

Reset
REQ-027 Reset SHALL force state=IDLE, starve_cnt=0, dbg_rdata=0, dbg_valid=0.
REQ-028 Reset asserted in a cycle with a granted debug read SHALL leave dbg_valid=0 next cycle; combinational outputs follow REQ-018..020 while reset is high.

Configuration
REQ-029 Macro DMEM_ARB_FAIRNESS_EN defined: starvation counter and forced debug grant as REQ-018/023/025.
REQ-030 Macro DMEM_ARB_FAIRNESS_EN undefined: starve_cnt SHALL not exist; gnt_dbg SHALL = dbg_req AND NOT cpu_req (strict CPU priority, cpu_stall constantly 0).

Verification
REQ-031 dbg_req=1 read addr 0x10, cpu_req=0, mem_rdata=0xE3A01005 -> dbg_gnt=1 same cycle, next cycle dbg_valid=1, dbg_rdata=0xE3A01005.
REQ-032 cpu_req=1 and dbg_req=1 held, STARVE_LIMIT=4, fairness on -> CPU granted cycles 0-3, cycle 4 dbg_gnt=1 and cpu_stall=1, cycle 5 CPU granted, cpu_stall=0.
REQ-033 Same stimulus, macro undefined -> dbg_gnt=0 and cpu_stall=0 for 20 cycles.
REQ-034 cpu write addr 0x20 size=1 data 0x0000002A, dbg idle -> mem_enable=1, mem_rw=1, mem_size=1, mem_addr=0x20, mem_wdata=0x2A, dbg_valid=0.
REQ-035 Granted debug read then reset=1 next edge -> dbg_valid=0, dbg_rdata=0, state=IDLE.
REQ-036 Both requests idle -> all mem_* outputs 0, cpu_stall=0, dbg_gnt=0.
